// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding and helpers.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t opposite_dir(dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of directions with head and tail peek outputs.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  dir_t                         din,
  output dir_t                         head,
  output dir_t                         tail,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH+1);

  dir_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign full     = (level_q == LvlW'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign do_push  = push & (~full | do_pop);
  assign tail_ptr = wr_ptr_q - PtrW'(1);
  assign head     = mem_q[rd_ptr_q];
  assign tail     = mem_q[tail_ptr];
  assign level    = level_q;

  // Storage write; contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and level counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_queue.sv
// Turns key-press pulses into the snake direction, one queued command per game step.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter bit          ALLOW_REVERSE = 1'b0
) (
  input  logic                       CLK_50M,
  input  logic                       RST,
  input  logic                       left_key_press,
  input  logic                       right_key_press,
  input  logic                       up_key_press,
  input  logic                       down_key_press,
  input  logic                       move_tick,
  output logic [1:0]                 dir,
  output logic                       dir_changed,
  output logic [$clog2(DEPTH+1)-1:0] queue_level,
  output logic                       overflow
);

  dir_t cmd, ref_dir, fifo_head, fifo_tail, dir_q;
  logic cmd_valid, accept, pop, fifo_full, fifo_empty;
  logic dir_changed_q, overflow_q;

  // Press encoder: up > down > left > right, lower presses discarded.
  always_comb begin
    cmd_valid = 1'b1;
    cmd       = DIR_UP;
    if (up_key_press)         cmd = DIR_UP;
    else if (down_key_press)  cmd = DIR_DOWN;
    else if (left_key_press)  cmd = DIR_LEFT;
    else if (right_key_press) cmd = DIR_RIGHT;
    else                      cmd_valid = 1'b0;
  end

  // Filter against the last direction that will be in effect: queue tail, else current dir.
  always_comb begin
    ref_dir = fifo_empty ? dir_q : fifo_tail;
    accept  = cmd_valid && (cmd != ref_dir) &&
              (ALLOW_REVERSE || (cmd != opposite_dir(ref_dir)));
  end

  // Pop only from a non-empty queue; a same-cycle push is not bypassed.
  assign pop = move_tick & ~fifo_empty;

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK_50M),
    .rst   (RST),
    .push  (accept),
    .pop   (pop),
    .din   (cmd),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (queue_level)
  );

  // Direction register and output pulse registers.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      dir_q         <= DIR_RIGHT;
      dir_changed_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (pop) dir_q <= fifo_head;
      dir_changed_q <= pop;
      overflow_q    <= accept & fifo_full & ~pop;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed, table-driven bench for snake_dir_queue (DEPTH=4, reversals filtered).
module tb_snake_dir_queue;

  localparam logic [1:0] U = 2'd0, D = 2'd1, L = 2'd2, R = 2'd3;
  // Key bit order in vectors: {up, down, left, right}
  localparam logic [3:0] K0 = 4'b0000, KU = 4'b1000, KD = 4'b0100, KL = 4'b0010, KR = 4'b0001;

  logic       clk = 1'b0;
  logic       rst, up_k, down_k, left_k, right_k, tick;
  logic [1:0] dir;
  logic       dir_changed, overflow;
  logic [2:0] queue_level;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       rst;
    logic [3:0] keys;
    logic       tick;
    logic [1:0] exp_dir;
    logic       exp_chg;
    logic [2:0] exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  snake_dir_queue #(
    .DEPTH         (4),
    .ALLOW_REVERSE (1'b0)
  ) dut (
    .CLK_50M         (clk),
    .RST             (rst),
    .left_key_press  (left_k),
    .right_key_press (right_k),
    .up_key_press    (up_k),
    .down_key_press  (down_k),
    .move_tick       (tick),
    .dir             (dir),
    .dir_changed     (dir_changed),
    .queue_level     (queue_level),
    .overflow        (overflow)
  );

  function automatic void add(logic r, logic [3:0] k, logic t, logic [1:0] ed, logic ec,
                              logic [2:0] el, logic eo);
    vec_t v;
    v.rst = r; v.keys = k; v.tick = t;
    v.exp_dir = ed; v.exp_chg = ec; v.exp_lvl = el; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic cmp(string nm, int act, int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next rising edge.
  task automatic apply(string tag, vec_t v);
    rst = v.rst; tick = v.tick;
    {up_k, down_k, left_k, right_k} = v.keys;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    cmp({tag, " dir"}, int'(dir), int'(v.exp_dir));
    cmp({tag, " dir_changed"}, int'(dir_changed), int'(v.exp_chg));
    cmp({tag, " queue_level"}, int'(queue_level), int'(v.exp_lvl));
    cmp({tag, " overflow"}, int'(overflow), int'(v.exp_ovf));
  endtask

  task automatic hand(string tag, logic r, logic [3:0] k, logic t, logic [1:0] ed, logic ec,
                      logic [2:0] el, logic eo);
    vec_t v;
    v.rst = r; v.keys = k; v.tick = t;
    v.exp_dir = ed; v.exp_chg = ec; v.exp_lvl = el; v.exp_ovf = eo;
    apply(tag, v);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0;
    {up_k, down_k, left_k, right_k} = K0;

    //   rst keys tick dir chg lvl ovf
    // Reset state and lone tick on empty queue
    add(1, K0, 0, R, 0, 0, 0);
    add(1, K0, 0, R, 0, 0, 0);
    add(0, K0, 0, R, 0, 0, 0);
    add(0, K0, 1, R, 0, 0, 0);
    // Queued sequence: up, left three cycles later, then two ticks
    add(0, KU, 0, R, 0, 1, 0);
    add(0, K0, 0, R, 0, 1, 0);
    add(0, K0, 0, R, 0, 1, 0);
    add(0, KL, 0, R, 0, 2, 0);
    add(0, K0, 1, U, 1, 1, 0);
    add(0, K0, 0, U, 0, 1, 0);
    add(0, K0, 1, L, 1, 0, 0);
    add(0, K0, 0, L, 0, 0, 0);
    // Filtering from dir=RIGHT
    add(1, K0, 0, R, 0, 0, 0);
    add(0, KL, 0, R, 0, 0, 0);
    add(0, KR, 0, R, 0, 0, 0);
    add(0, KU, 0, R, 0, 1, 0);
    add(0, KD, 0, R, 0, 1, 0);
    add(0, K0, 1, U, 1, 0, 0);
    // Overflow: fill with up, left, down, right, then up with and without a tick
    add(1, K0, 0, R, 0, 0, 0);
    add(0, KU, 0, R, 0, 1, 0);
    add(0, KL, 0, R, 0, 2, 0);
    add(0, KD, 0, R, 0, 3, 0);
    add(0, KR, 0, R, 0, 4, 0);
    add(0, KU, 0, R, 0, 4, 1);
    add(0, K0, 0, R, 0, 4, 0);
    add(0, KU, 1, U, 1, 4, 0);
    add(0, K0, 0, U, 0, 4, 0);
    // Simultaneous presses, then push on empty queue with coincident tick
    add(1, K0, 0, R, 0, 0, 0);
    add(0, KU | KL, 0, R, 0, 1, 0);
    add(0, K0, 1, U, 1, 0, 0);
    add(0, KL, 1, U, 0, 1, 0);
    add(0, K0, 1, L, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-queue: reach dir=UP with three entries queued, then flush.
    hand("midq_u",    0, KU, 0, L, 0, 1, 0);
    hand("midq_r",    0, KR, 0, L, 0, 2, 0);
    hand("midq_t",    0, K0, 1, U, 1, 1, 0);
    hand("midq_d",    0, KD, 0, U, 0, 2, 0);
    hand("midq_l",    0, KL, 0, U, 0, 3, 0);
    hand("midq_rst",  1, K0, 0, R, 0, 0, 0);
    hand("midq_tick", 0, K0, 1, R, 0, 0, 0);
    hand("midq_idle", 0, K0, 0, R, 0, 0, 0);

    // Back-to-back pops keep dir_changed high; overflow cannot fire during a pop.
    hand("b2b_u",  0, KU, 0, R, 0, 1, 0);
    hand("b2b_l",  0, KL, 0, R, 0, 2, 0);
    hand("b2b_t1", 0, K0, 1, U, 1, 1, 0);
    hand("b2b_t2", 0, K0, 1, L, 1, 0, 0);
    hand("b2b_t3", 0, K0, 1, L, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
